alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential 16-bit ALU: one-cycle EXEC path, optional 16-step shift-add MUL path.
// Define ALU_SEQ_MUL_EN to compile in the multiplier and the MUL state.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] write,
  output logic        rw,
  output logic        zero,
  output logic        carry,
  output logic        ovf
);

  localparam int unsigned W  = 16;
  localparam int unsigned OW = 3;

  localparam logic [OW-1:0] OP_ADD = 3'd0;
  localparam logic [OW-1:0] OP_SUB = 3'd1;
  localparam logic [OW-1:0] OP_AND = 3'd2;
  localparam logic [OW-1:0] OP_OR  = 3'd3;
  localparam logic [OW-1:0] OP_XOR = 3'd4;
  localparam logic [OW-1:0] OP_SHL = 3'd5;
  localparam logic [OW-1:0] OP_SHR = 3'd6;
  localparam logic [OW-1:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [OW-1:0] op_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;

  logic          accept;
  logic          mul_last;

  assign accept = (state == S_IDLE) && start;

  // Operand capture on acceptance; held for the whole operation
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= '0;
      a_r  <= '0;
      b_r  <= '0;
    end else if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc_step;
  logic [W-1:0]   mplier;
  logic [3:0]     cnt;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
    end
  end
`else
  assign mul_last = 1'b0;
`endif

  // Single-cycle ALU on the captured operands
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;
  logic [W:0]   sum_w;
  logic [W:0]   sh_w;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = '0;
    sh_w    = '0;
    case (op_r)
      OP_ADD: begin
        sum_w   = {1'b0, a_r} + {1'b0, b_r};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (a_r[W-1] == b_r[W-1]) && (alu_res[W-1] != a_r[W-1]);
      end
      OP_SUB: begin
        sum_w   = {1'b0, a_r} - {1'b0, b_r};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (a_r[W-1] != b_r[W-1]) && (alu_res[W-1] != a_r[W-1]);
      end
      OP_AND: alu_res = a_r & b_r;
      OP_OR:  alu_res = a_r | b_r;
      OP_XOR: alu_res = a_r ^ b_r;
      // The extra bit beside the word catches the last bit shifted out
      OP_SHL: begin
        sh_w    = {1'b0, a_r} << b_r[3:0];
        alu_res = sh_w[W-1:0];
        alu_c   = sh_w[W];
      end
      OP_SHR: begin
        sh_w    = {a_r, 1'b0} >> b_r[3:0];
        alu_res = sh_w[W:1];
        alu_c   = sh_w[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_SEQ_MUL_EN
          state_nx = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_nx = S_EXEC;
`endif
        end
      end
      S_EXEC:  state_nx = S_DONE;
      S_MUL:   state_nx = mul_last ? S_DONE : S_MUL;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output next-values, derived from the state being entered
  logic         busy_d;
  logic         done_d;
  logic         load_d;
  logic [W-1:0] res_d;
  logic         c_d;
  logic         v_d;

  always_comb begin
    busy_d = (state_nx != S_IDLE);
    done_d = (state_nx == S_DONE);
    load_d = (state_nx == S_DONE);
    res_d  = alu_res;
    c_d    = alu_c;
    v_d    = alu_v;
`ifdef ALU_SEQ_MUL_EN
    if (state == S_MUL) begin
      res_d = acc_step[W-1:0];
      c_d   = |acc_step[2*W-1:W];
      v_d   = 1'b0;
    end
`endif
  end

  // Registered outputs; result and flags load only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      rw    <= 1'b0;
      write <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      rw   <= done_d;
      if (load_d) begin
        write <= res_d;
        zero  <= (res_d == '0);
        carry <= c_d;
        ovf   <= v_d;
      end
    end
  end

endmodule
